// File: rtl/lsu_pkg.sv
// Shared types and sizing for the vector load/store sequencer.
// Lane NLANES-1 carries element 0 (the scalar lane).
package lsu_pkg;

  localparam int NLANES = 16;
  localparam int WORD_W = 32;
  localparam int LIDX_W = $clog2(NLANES);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    DRAIN,
    STORE,
    WB
  } state_t;

  typedef logic [NLANES-1:0][WORD_W-1:0] lane_vec_t;

  function automatic logic [LIDX_W-1:0] lane_of(
    input logic [LIDX_W-1:0] k
  );
    return LIDX_W'(NLANES - 1) - k;
  endfunction

endpackage

// File: rtl/lsu_addr_gen.sv
// Element counter and running-sum address generator.
// The address for element k is base + k*stride, wrapping mod 2^32.
module lsu_addr_gen
  import lsu_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              step,
  input  logic [31:0]       base,
  input  logic [31:0]       stride,
  input  logic [LIDX_W-1:0] last_idx,
  output logic [31:0]       addr,
  output logic [LIDX_W-1:0] cnt,
  output logic              last
);

  logic [31:0]       stride_q;
  logic [LIDX_W-1:0] last_q;

  assign last = (cnt == last_q);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr     <= '0;
      cnt      <= '0;
      stride_q <= '0;
      last_q   <= '0;
    end else if (load) begin
      addr     <= base;
      cnt      <= '0;
      stride_q <= stride;
      last_q   <= last_idx;
    end else if (step) begin
      addr <= addr + stride_q;
      cnt  <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/vector_lsu_seq.sv
// Serialises 16-lane vector (or scalar) loads/stores onto a
// single-port 32-bit data memory, with one-beat load writeback.
module vector_lsu_seq
  import lsu_pkg::*;
#(
  parameter int MEM_LAT = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic                          is_store,
  input  logic                          is_vec,
  input  logic [31:0]                   base_addr,
  input  logic [31:0]                   stride,
  input  logic [NLANES-1:0][WORD_W-1:0] st_data,
  input  logic [3:0]                    dst_reg,
  input  logic                          abort,
  output logic [31:0]                   mem_addr,
  output logic                          mem_we,
  output logic [31:0]                   mem_wdata,
  input  logic [31:0]                   mem_rdata,
  output logic                          busy,
  output logic                          stall,
  output logic                          wb_we,
  output logic                          wb_vs,
  output logic [3:0]                    wb_ra3,
  output logic [NLANES-1:0][WORD_W-1:0] wb_data,
  output logic                          done
);

  state_t            state, nstate;
  logic              accept, issuing, last;
  logic [LIDX_W-1:0] cnt;
  logic [31:0]       addr;
  logic              vec_q;
  logic [3:0]        dst_q;
  lane_vec_t         st_q, lbuf;
  logic [MEM_LAT-1:0] pv;
  logic [LIDX_W-1:0] pl [MEM_LAT];

  assign accept  = (state == IDLE) && start;
  assign issuing = (state == LOAD) || (state == STORE);

  lsu_addr_gen u_agen (
    .clk      (clk),
    .rst      (rst),
    .load     (accept),
    .step     (issuing),
    .base     (base_addr),
    .stride   (stride),
    .last_idx (is_vec ? LIDX_W'(NLANES - 1) : '0),
    .addr     (addr),
    .cnt      (cnt),
    .last     (last)
  );

  always_comb begin
    nstate = state;
    unique case (state)
      IDLE:  if (start) nstate = is_store ? STORE : LOAD;
      LOAD:  if (abort) nstate = IDLE;
             else if (last) nstate = DRAIN;
      DRAIN: if (abort) nstate = IDLE;
             else if (!(|pv)) nstate = WB;
      STORE: if (abort || last) nstate = IDLE;
      WB:    nstate = IDLE;
      default: nstate = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= nstate;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vec_q <= 1'b0;
      dst_q <= '0;
      st_q  <= '0;
    end else if (accept) begin
      vec_q <= is_vec;
      dst_q <= dst_reg;
      st_q  <= st_data;
    end
  end

  // Lane tag rides alongside the memory latency to steer mem_rdata
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pv <= '0;
      for (int i = 0; i < MEM_LAT; i++) pl[i] <= '0;
    end else begin
      for (int i = MEM_LAT - 1; i > 0; i--) begin
        pv[i] <= pv[i-1] & ~abort;
        pl[i] <= pl[i-1];
      end
      pv[0] <= (state == LOAD) & ~abort;
      pl[0] <= lane_of(cnt);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                lbuf <= '0;
    else if (accept)         lbuf <= '0;
    else if (pv[MEM_LAT-1])  lbuf[pl[MEM_LAT-1]] <= mem_rdata;
  end

  assign busy      = (state != IDLE);
  assign stall     = busy;
  assign mem_addr  = addr;
  assign mem_we    = (state == STORE);
  assign mem_wdata = mem_we ? st_q[lane_of(cnt)] : '0;
  assign wb_we     = (state == WB);
  assign wb_vs     = wb_we & vec_q;
  assign wb_ra3    = wb_we ? dst_q : '0;
  assign wb_data   = lbuf;
  assign done      = wb_we | (mem_we & last);

endmodule

// File: tb/tb_vector_lsu_seq.sv
// Directed bench for vector_lsu_seq; runs MEM_LAT=1 and MEM_LAT=3
// instances side by side from the same stimulus.
module tb_vector_lsu_seq;
  import lsu_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic        start, is_store, is_vec, abort;
  logic [31:0] base_addr, stride;
  lane_vec_t   st_data;
  logic [3:0]  dst_reg;

  logic [31:0] mem_addr_a, mem_wdata_a, mem_rdata_a;
  logic        mem_we_a, busy_a, stall_a, wb_we_a, wb_vs_a, done_a;
  logic [3:0]  wb_ra3_a;
  lane_vec_t   wb_data_a;

  logic [31:0] mem_addr_b, mem_wdata_b, mem_rdata_b;
  logic        mem_we_b, busy_b, stall_b, wb_we_b, wb_vs_b, done_b;
  logic [3:0]  wb_ra3_b;
  lane_vec_t   wb_data_b;

  vector_lsu_seq #(.MEM_LAT(1)) dut (
    .clk(clk), .rst(rst), .start(start), .is_store(is_store),
    .is_vec(is_vec), .base_addr(base_addr), .stride(stride),
    .st_data(st_data), .dst_reg(dst_reg), .abort(abort),
    .mem_addr(mem_addr_a), .mem_we(mem_we_a),
    .mem_wdata(mem_wdata_a), .mem_rdata(mem_rdata_a),
    .busy(busy_a), .stall(stall_a), .wb_we(wb_we_a),
    .wb_vs(wb_vs_a), .wb_ra3(wb_ra3_a), .wb_data(wb_data_a),
    .done(done_a)
  );

  vector_lsu_seq #(.MEM_LAT(3)) dut3 (
    .clk(clk), .rst(rst), .start(start), .is_store(is_store),
    .is_vec(is_vec), .base_addr(base_addr), .stride(stride),
    .st_data(st_data), .dst_reg(dst_reg), .abort(abort),
    .mem_addr(mem_addr_b), .mem_we(mem_we_b),
    .mem_wdata(mem_wdata_b), .mem_rdata(mem_rdata_b),
    .busy(busy_b), .stall(stall_b), .wb_we(wb_we_b),
    .wb_vs(wb_vs_b), .wb_ra3(wb_ra3_b), .wb_data(wb_data_b),
    .done(done_b)
  );

  function automatic logic [31:0] memval(input logic [31:0] a);
    return (a == 32'd5) ? 32'h0000_DEAD : a;
  endfunction

  logic [31:0] d1;
  logic [31:0] q3 [3];
  always @(posedge clk) begin
    d1    <= memval(mem_addr_a);
    q3[0] <= memval(mem_addr_b);
    q3[1] <= q3[0];
    q3[2] <= q3[1];
  end
  assign mem_rdata_a = d1;
  assign mem_rdata_b = q3[2];

  int nvec = 0;
  int nerr = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  int edge_n = 0;
  always @(posedge clk) edge_n <= edge_n + 1;

  int          t0;
  int          lat_a, lat_b, wb_n_a, wb_n_b, done_n, done_wr, wr_n;
  lane_vec_t   wbd_a, wbd_b;
  logic        vs_a;
  logic [3:0]  ra_a;
  logic [31:0] wr_addr [32];
  logic [31:0] wr_data [32];

  always @(negedge clk) begin
    if (wb_we_a) begin
      wb_n_a++;
      lat_a = edge_n - t0;
      wbd_a = wb_data_a;
      vs_a  = wb_vs_a;
      ra_a  = wb_ra3_a;
    end
    if (wb_we_b) begin
      wb_n_b++;
      lat_b = edge_n - t0;
      wbd_b = wb_data_b;
    end
    if (done_a) begin
      done_n++;
      if (mem_we_a) done_wr = wr_n + 1;
    end
    if (mem_we_a && wr_n < 32) begin
      wr_addr[wr_n] = mem_addr_a;
      wr_data[wr_n] = mem_wdata_a;
      wr_n++;
    end
  end

  task automatic clear_mon();
    lat_a = -1; lat_b = -1;
    wb_n_a = 0; wb_n_b = 0;
    done_n = 0; done_wr = 0; wr_n = 0;
    wbd_a = '0; wbd_b = '0;
    vs_a = 1'b0; ra_a = '0;
  endtask

  task automatic launch(input logic st, input logic vec,
                        input logic [31:0] b, input logic [31:0] s,
                        input logic [3:0] d, input logic ab);
    @(negedge clk);
    start = 1'b1; is_store = st; is_vec = vec;
    base_addr = b; stride = s; dst_reg = d; abort = ab;
    @(posedge clk);
    #1;
    t0 = edge_n;
    start = 1'b0;
    abort = 1'b0;
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 60 && !ok; i++) begin
      @(negedge clk);
      if (!busy_a && !busy_b) ok = 1'b1;
    end
    if (!ok) chk("idle_timeout", 32'd1, 32'd0);
  endtask

  initial begin
    int bad;
    start = 1'b0; is_store = 1'b0; is_vec = 1'b0; abort = 1'b0;
    base_addr = '0; stride = '0; dst_reg = '0;
    for (int i = 0; i < NLANES; i++) st_data[i] = 32'(i);
    t0 = 0;
    clear_mon();

    repeat (3) @(negedge clk);
    chk("rst_busy",  32'(busy_a),  32'd0);
    chk("rst_stall", 32'(stall_a), 32'd0);
    chk("rst_we",    32'(mem_we_a), 32'd0);
    chk("rst_addr",  mem_addr_a,   32'd0);
    chk("rst_wbwe",  32'(wb_we_a), 32'd0);
    chk("rst_done",  32'(done_a),  32'd0);
    chk("rst_wbd",   32'(|wb_data_a), 32'd0);
    rst = 1'b1;

    // vector load, mem[a]=a
    clear_mon();
    launch(1'b0, 1'b1, 32'd48, 32'd1, 4'd7, 1'b0);
    wait_idle();
    chk("vld_lat1",  32'(lat_a), 32'd18);
    chk("vld_lat3",  32'(lat_b), 32'd20);
    chk("vld_l15",   wbd_a[15], 32'd48);
    chk("vld_l0",    wbd_a[0],  32'd63);
    chk("vld_l8_b",  wbd_b[8],  32'd55);
    chk("vld_vs",    32'(vs_a), 32'd1);
    chk("vld_ra3",   32'(ra_a), 32'd7);
    chk("vld_wbn",   32'(wb_n_a), 32'd1);
    chk("vld_done",  32'(done_n), 32'd1);

    // vector store
    clear_mon();
    launch(1'b1, 1'b1, 32'd82, 32'd16, 4'd0, 1'b0);
    wait_idle();
    chk("vst_n", 32'(wr_n), 32'd16);
    for (int i = 0; i < 16; i++) begin
      chk("vst_addr", wr_addr[i], 32'(82 + 16 * i));
      chk("vst_data", wr_data[i], 32'(15 - i));
    end
    chk("vst_done",   32'(done_n),  32'd1);
    chk("vst_donewr", 32'(done_wr), 32'd16);
    chk("vst_wbn",    32'(wb_n_a),  32'd0);

    // scalar load, abort held high in IDLE must not matter
    clear_mon();
    launch(1'b0, 1'b0, 32'd5, 32'd4, 4'd3, 1'b1);
    wait_idle();
    chk("sld_lat1", 32'(lat_a), 32'd3);
    chk("sld_lat3", 32'(lat_b), 32'd5);
    chk("sld_l15",  wbd_a[15], 32'h0000_DEAD);
    chk("sld_lo",   32'(|wbd_a[14:0]), 32'd0);
    chk("sld_vs",   32'(vs_a), 32'd0);
    chk("sld_ra3",  32'(ra_a), 32'd3);

    // address wrap
    clear_mon();
    launch(1'b0, 1'b1, 32'hFFFF_FFFE, 32'd1, 4'd2, 1'b0);
    wait_idle();
    chk("wrap_l15", wbd_a[15], 32'hFFFF_FFFE);
    chk("wrap_l14", wbd_a[14], 32'hFFFF_FFFF);
    chk("wrap_l13", wbd_a[13], 32'd0);
    chk("wrap_l0",  wbd_a[0],  32'd13);
    chk("wrap_l0b", wbd_b[0],  32'd13);

    // stride 0 broadcast
    clear_mon();
    launch(1'b0, 1'b1, 32'hFFFF_FFFE, 32'd0, 4'd2, 1'b0);
    wait_idle();
    bad = 0;
    for (int i = 0; i < NLANES; i++)
      if (wbd_a[i] !== 32'hFFFF_FFFE || wbd_b[i] !== 32'hFFFF_FFFE)
        bad++;
    chk("bcast_bad", 32'(bad), 32'd0);
    chk("bcast_wbn", 32'(wb_n_a + wb_n_b), 32'd2);

    // abort a store at issue 5
    clear_mon();
    launch(1'b1, 1'b1, 32'd82, 32'd16, 4'd0, 1'b0);
    repeat (6) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abt_busy", 32'(busy_a), 32'd0);
    repeat (4) @(negedge clk);
    chk("abt_wrn",  32'(wr_n),   32'd6);
    chk("abt_addr", wr_addr[5],  32'd162);
    chk("abt_done", 32'(done_n), 32'd0);
    clear_mon();
    launch(1'b0, 1'b1, 32'd48, 32'd1, 4'd9, 1'b0);
    wait_idle();
    chk("abt_next_wbn", 32'(wb_n_a), 32'd1);
    chk("abt_next_l0",  wbd_a[0],    32'd63);

    // reset mid-load
    clear_mon();
    launch(1'b0, 1'b1, 32'd48, 32'd1, 4'd1, 1'b0);
    repeat (8) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("mrst_busy", 32'(busy_a), 32'd0);
    chk("mrst_addr", mem_addr_a,  32'd0);
    chk("mrst_wbd",  32'(|wb_data_a), 32'd0);
    repeat (25) @(negedge clk);
    chk("mrst_wbn",  32'(wb_n_a + wb_n_b), 32'd0);
    rst = 1'b1;

    // start held high while busy
    clear_mon();
    @(negedge clk);
    start = 1'b1; is_store = 1'b0; is_vec = 1'b1;
    base_addr = 32'd48; stride = 32'd1; dst_reg = 4'd4;
    @(posedge clk);
    #1;
    t0 = edge_n;
    repeat (17) @(negedge clk);
    start = 1'b0;
    wait_idle();
    repeat (3) @(negedge clk);
    chk("hold_wbn",  32'(wb_n_a), 32'd1);
    chk("hold_done", 32'(done_n), 32'd1);
    chk("hold_lat",  32'(lat_a),  32'd18);
    chk("hold_wbnb", 32'(wb_n_b), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
